dma_write_packer: RTL and testbench

Width-up packer between the HyperLogLog result writer and the host DMA write channel. It accepts one DMA write command (64-bit address, 32-bit byte length) plus a stream of 32-bit result words, and forwards the command unchanged. It packs the words into 512-bit DMA write beats with an exact byte keep, and checks that the delivered byte count equals the commanded length. It sits between the HLL core's write outputs and the role's `m_axis_dma_write_cmd` / `m_axis_dma_write_data` ports.

---
 rtl/dma_pack_pkg.sv | 42 ++++
 rtl/dma_write_packer.sv | 207 ++++++++++++++++++++
 tb/tb_dma_write_packer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pack_pkg.sv
// ============================================================================
// Package : dma_pack_pkg - shared types and helpers for dma_write_packer
// Rev     : 1.0
// ============================================================================
`default_nettype none

package dma_pack_pkg;

    localparam int IN_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF = 512;
    // Widest input keep the popcount helper accepts (512-bit input words).
    localparam int KEEP_MAX      = 64;

    function automatic int calc_lanes(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

    function automatic int calc_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANES = calc_lanes(IN_WIDTH_DEF, OUT_WIDTH_DEF);
    localparam int IDX_W = calc_idx_w(LANES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD_OUT = 2'd1,
        DATA    = 2'd2
    } state_t;

    function automatic logic [31:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            cnt = cnt + 32'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_write_packer.sv
// ============================================================================
// Module : dma_write_packer - width-up packer from result words to DMA beats
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dma_write_packer
    import dma_pack_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 512
) (
    input  logic                   user_clk,
    input  logic                   user_aresetn,

    input  logic                   s_axis_cmd_valid,
    output logic                   s_axis_cmd_ready,
    input  logic [63:0]            s_axis_cmd_address,
    input  logic [31:0]            s_axis_cmd_length,

    input  logic                   s_axis_data_valid,
    output logic                   s_axis_data_ready,
    input  logic [IN_WIDTH-1:0]    s_axis_data_data,
    input  logic [IN_WIDTH/8-1:0]  s_axis_data_keep,
    input  logic                   s_axis_data_last,

    output logic                   m_axis_dma_write_cmd_valid,
    input  logic                   m_axis_dma_write_cmd_ready,
    output logic [63:0]            m_axis_dma_write_cmd_address,
    output logic [31:0]            m_axis_dma_write_cmd_length,

    output logic                   m_axis_dma_write_data_valid,
    input  logic                   m_axis_dma_write_data_ready,
    output logic [OUT_WIDTH-1:0]   m_axis_dma_write_data_data,
    output logic [OUT_WIDTH/8-1:0] m_axis_dma_write_data_keep,
    output logic                   m_axis_dma_write_data_last,

    output logic                   err_length_mismatch,
    output logic [31:0]            stat_beats_out,
    output logic [31:0]            stat_bytes_in
);

    localparam int N_LANES    = calc_lanes(IN_WIDTH, OUT_WIDTH);
    localparam int N_IDX_W    = calc_idx_w(N_LANES);
    localparam int IN_KEEP_W  = IN_WIDTH / 8;
    localparam int OUT_KEEP_W = OUT_WIDTH / 8;
    localparam logic [N_IDX_W-1:0] LAST_IDX = N_IDX_W'(N_LANES - 1);

    state_t                  state_q, state_d;
    logic [63:0]             addr_q, addr_d;
    logic [31:0]             len_q, len_d;
    logic [N_IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]             xfer_bytes_q, xfer_bytes_d;
    logic [OUT_WIDTH-1:0]    buf_data_q, buf_data_d;
    logic [OUT_KEEP_W-1:0]   buf_keep_q, buf_keep_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic [OUT_KEEP_W-1:0]   out_keep_q, out_keep_d;
    logic                    err_q, err_d;
    logic [31:0]             beats_q, beats_d;
    logic [31:0]             bytes_in_q, bytes_in_d;

    logic [OUT_WIDTH-1:0]    w_merge_data;
    logic [OUT_KEEP_W-1:0]   w_merge_keep;
    logic [31:0]             w_word_bytes;
    logic                    w_data_ready;

    assign w_data_ready = (state_q == DATA) && (!out_valid_q || m_axis_dma_write_data_ready);
    assign w_word_bytes = keep_popcount(KEEP_MAX'(s_axis_data_keep));

    assign s_axis_cmd_ready             = (state_q == IDLE);
    assign s_axis_data_ready            = w_data_ready;
    assign m_axis_dma_write_cmd_valid   = (state_q == CMD_OUT);
    assign m_axis_dma_write_cmd_address = addr_q;
    assign m_axis_dma_write_cmd_length  = len_q;
    assign m_axis_dma_write_data_valid  = out_valid_q;
    assign m_axis_dma_write_data_data   = out_data_q;
    assign m_axis_dma_write_data_keep   = out_keep_q;
    assign m_axis_dma_write_data_last   = out_last_q;
    assign err_length_mismatch          = err_q;
    assign stat_beats_out               = beats_q;
    assign stat_bytes_in                = bytes_in_q;

    // Pack buffer with the incoming word dropped into lane idx.
    always_comb begin
        w_merge_data = buf_data_q;
        w_merge_keep = buf_keep_q;
        for (int l = 0; l < N_LANES; l++) begin
            if (idx_q == N_IDX_W'(l)) begin
                w_merge_data[l*IN_WIDTH +: IN_WIDTH]   = s_axis_data_data;
                w_merge_keep[l*IN_KEEP_W +: IN_KEEP_W] = s_axis_data_keep;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        xfer_bytes_d = xfer_bytes_q;
        buf_data_d   = buf_data_q;
        buf_keep_d   = buf_keep_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        err_d        = err_q;
        beats_d      = beats_q;
        bytes_in_d   = bytes_in_q;

        // Drain first so a same-cycle load below overrides it without a bubble.
        if (out_valid_q && m_axis_dma_write_data_ready) begin
            out_valid_d = 1'b0;
            beats_d     = beats_q + 32'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (s_axis_cmd_valid) begin
                    addr_d       = s_axis_cmd_address;
                    len_d        = s_axis_cmd_length;
                    xfer_bytes_d = '0;
                    state_d      = CMD_OUT;
                end
            end

            CMD_OUT: begin
                if (m_axis_dma_write_cmd_ready) begin
                    state_d = (len_q != 32'd0) ? DATA : IDLE;
                end
            end

            DATA: begin
                if (s_axis_data_valid && w_data_ready) begin
                    xfer_bytes_d = xfer_bytes_q + w_word_bytes;
                    bytes_in_d   = bytes_in_q + w_word_bytes;
                    if (idx_q == LAST_IDX || s_axis_data_last) begin
                        out_data_d  = w_merge_data;
                        out_keep_d  = w_merge_keep;
                        out_valid_d = 1'b1;
                        out_last_d  = s_axis_data_last;
                        buf_data_d  = '0;
                        buf_keep_d  = '0;
                        idx_d       = '0;
                    end else begin
                        buf_data_d  = w_merge_data;
                        buf_keep_d  = w_merge_keep;
                        idx_d       = idx_q + N_IDX_W'(1);
                    end
                    if (s_axis_data_last) begin
                        if (xfer_bytes_d != len_q) begin
                            err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            xfer_bytes_q <= '0;
            buf_data_q   <= '0;
            buf_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            err_q        <= 1'b0;
            beats_q      <= '0;
            bytes_in_q   <= '0;
        end else begin
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            xfer_bytes_q <= xfer_bytes_d;
            buf_data_q   <= buf_data_d;
            buf_keep_q   <= buf_keep_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            err_q        <= err_d;
            beats_q      <= beats_d;
            bytes_in_q   <= bytes_in_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_write_packer.sv
// ============================================================================
// Module : tb_dma_write_packer - directed self-checking bench for dma_write_packer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dma_write_packer;

    logic         user_clk = 1'b0;
    logic         user_aresetn;
    logic         s_axis_cmd_valid;
    logic         s_axis_cmd_ready;
    logic [63:0]  s_axis_cmd_address;
    logic [31:0]  s_axis_cmd_length;
    logic         s_axis_data_valid;
    logic         s_axis_data_ready;
    logic [31:0]  s_axis_data_data;
    logic [3:0]   s_axis_data_keep;
    logic         s_axis_data_last;
    logic         m_cmd_valid;
    logic         m_cmd_ready;
    logic [63:0]  m_cmd_address;
    logic [31:0]  m_cmd_length;
    logic         m_data_valid;
    logic         m_data_ready;
    logic [511:0] m_data_data;
    logic [63:0]  m_data_keep;
    logic         m_data_last;
    logic         err_length_mismatch;
    logic [31:0]  stat_beats_out;
    logic [31:0]  stat_bytes_in;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    int           errors   = 0;
    int           checks   = 0;
    int           words_in = 0;
    int           w0;
    logic [95:0]  cmd_q[$];
    beat_t        beat_q[$];

    localparam logic [63:0] KEEP_ALL = {64{1'b1}};

    always #5 user_clk = ~user_clk;

    dma_write_packer #(.IN_WIDTH(32), .OUT_WIDTH(512)) dut (
        .user_clk                     (user_clk),
        .user_aresetn                 (user_aresetn),
        .s_axis_cmd_valid             (s_axis_cmd_valid),
        .s_axis_cmd_ready             (s_axis_cmd_ready),
        .s_axis_cmd_address           (s_axis_cmd_address),
        .s_axis_cmd_length            (s_axis_cmd_length),
        .s_axis_data_valid            (s_axis_data_valid),
        .s_axis_data_ready            (s_axis_data_ready),
        .s_axis_data_data             (s_axis_data_data),
        .s_axis_data_keep             (s_axis_data_keep),
        .s_axis_data_last             (s_axis_data_last),
        .m_axis_dma_write_cmd_valid   (m_cmd_valid),
        .m_axis_dma_write_cmd_ready   (m_cmd_ready),
        .m_axis_dma_write_cmd_address (m_cmd_address),
        .m_axis_dma_write_cmd_length  (m_cmd_length),
        .m_axis_dma_write_data_valid  (m_data_valid),
        .m_axis_dma_write_data_ready  (m_data_ready),
        .m_axis_dma_write_data_data   (m_data_data),
        .m_axis_dma_write_data_keep   (m_data_keep),
        .m_axis_dma_write_data_last   (m_data_last),
        .err_length_mismatch          (err_length_mismatch),
        .stat_beats_out               (stat_beats_out),
        .stat_bytes_in                (stat_bytes_in)
    );

    // Inputs change just after posedge, so at negedge a valid&&ready pair
    // is exactly the handshake that the following posedge will complete.
    always @(negedge user_clk) begin
        if (user_aresetn) begin
            if (m_cmd_valid && m_cmd_ready)
                cmd_q.push_back({m_cmd_address, m_cmd_length});
            if (m_data_valid && m_data_ready)
                beat_q.push_back('{data: m_data_data, keep: m_data_keep, last: m_data_last});
            if (s_axis_data_valid && s_axis_data_ready)
                words_in++;
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_data(input logic [31:0] base, input int n);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
        logic ok;
        ok = 1'b0;
        s_axis_cmd_valid   = 1'b1;
        s_axis_cmd_address = a;
        s_axis_cmd_length  = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge user_clk);
            ok = s_axis_cmd_ready;
            @(posedge user_clk);
            #1;
        end
        s_axis_cmd_valid = 1'b0;
        check("cmd_accept", ok, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic ok;
        ok = 1'b0;
        s_axis_data_valid = 1'b1;
        s_axis_data_data  = d;
        s_axis_data_keep  = k;
        s_axis_data_last  = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge user_clk);
            ok = s_axis_data_ready;
            @(posedge user_clk);
            #1;
        end
        s_axis_data_valid = 1'b0;
        check("word_accept", ok, 1'b1);
    endtask

    task automatic expect_beat(input string tag, input logic [511:0] d, input logic [63:0] k,
                               input logic l);
        beat_t b;
        b = '0;
        for (int n = 0; n < 100 && beat_q.size() == 0; n++) begin
            @(negedge user_clk);
            #1;
        end
        if (beat_q.size() != 0) b = beat_q.pop_front();
        check({tag, "_data"}, b.data, d);
        check({tag, "_keep"}, 512'(b.keep), 512'(k));
        check({tag, "_last"}, 512'(b.last), 512'(l));
    endtask

    task automatic expect_cmd(input string tag, input logic [63:0] a, input logic [31:0] l);
        logic [95:0] c;
        c = '0;
        for (int n = 0; n < 100 && cmd_q.size() == 0; n++) begin
            @(negedge user_clk);
            #1;
        end
        if (cmd_q.size() != 0) c = cmd_q.pop_front();
        check({tag, "_cmd_addr"}, 512'(c[95:32]), 512'(a));
        check({tag, "_cmd_len"}, 512'(c[31:0]), 512'(l));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        user_aresetn       = 1'b0;
        s_axis_cmd_valid   = 1'b0;
        s_axis_cmd_address = '0;
        s_axis_cmd_length  = '0;
        s_axis_data_valid  = 1'b0;
        s_axis_data_data   = '0;
        s_axis_data_keep   = '0;
        s_axis_data_last   = 1'b0;
        m_cmd_ready        = 1'b1;
        m_data_ready       = 1'b1;

        // Reset values
        #12;
        check("rst_cmd_ready", s_axis_cmd_ready, 1'b1);
        check("rst_cmd_valid", m_cmd_valid, 1'b0);
        check("rst_data_valid", m_data_valid, 1'b0);
        check("rst_data_ready", s_axis_data_ready, 1'b0);
        check("rst_err", err_length_mismatch, 1'b0);
        check("rst_stats", {stat_beats_out, stat_bytes_in}, 64'd0);
        @(posedge user_clk); #1;
        user_aresetn = 1'b1;
        @(posedge user_clk); #1;

        // Full beat
        send_cmd(64'h1000, 32'd64);
        check("t1_cmd_valid_lat", m_cmd_valid, 1'b1);
        check("t1_cmd_addr_out", m_cmd_address, 64'h1000);
        check("t1_cmd_len_out", m_cmd_length, 32'd64);
        for (int i = 0; i < 16; i++) send_word(32'(i), 4'hF, i == 15);
        check("t1_beat_valid_lat", m_data_valid, 1'b1);
        expect_beat("t1", make_data(32'h0, 16), KEEP_ALL, 1'b1);
        expect_cmd("t1", 64'h1000, 32'd64);
        @(posedge user_clk); #1;
        check("t1_err", err_length_mismatch, 1'b0);
        check("t1_beats", stat_beats_out, 32'd1);
        check("t1_bytes", stat_bytes_in, 32'd64);

        // Partial tail: 17 full words + 2-byte last word = 70 bytes
        send_cmd(64'h1100, 32'd70);
        for (int i = 0; i < 18; i++)
            send_word(32'h100 + 32'(i), (i == 17) ? 4'h3 : 4'hF, i == 17);
        expect_beat("t2a", make_data(32'h100, 16), KEEP_ALL, 1'b0);
        expect_beat("t2b", make_data(32'h110, 2), 64'h3F, 1'b1);
        expect_cmd("t2", 64'h1100, 32'd70);
        @(posedge user_clk); #1;
        check("t2_err", err_length_mismatch, 1'b0);
        check("t2_beats", stat_beats_out, 32'd3);
        check("t2_bytes", stat_bytes_in, 32'd134);

        // Length mismatch: 32 bytes delivered against 64 commanded
        send_cmd(64'h1200, 32'd64);
        for (int i = 0; i < 8; i++) send_word(32'h200 + 32'(i), 4'hF, i == 7);
        check("t3_err_set", err_length_mismatch, 1'b1);
        expect_beat("t3", make_data(32'h200, 8), 64'hFFFF_FFFF, 1'b1);
        expect_cmd("t3", 64'h1200, 32'd64);
        @(posedge user_clk); #1;
        check("t3_beats", stat_beats_out, 32'd4);
        check("t3_bytes", stat_bytes_in, 32'd166);

        // Backpressure while beat 1 forms and is held
        w0 = words_in;
        m_data_ready = 1'b0;
        send_cmd(64'h1300, 32'd128);
        for (int i = 0; i < 16; i++) send_word(32'h300 + 32'(i), 4'hF, 1'b0);
        check("t4_hold_valid", m_data_valid, 1'b1);
        check("t4_ready_drop", s_axis_data_ready, 1'b0);
        s_axis_data_valid = 1'b1;
        s_axis_data_data  = 32'h310;
        s_axis_data_keep  = 4'hF;
        s_axis_data_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge user_clk);
            check("t4_stall_ready", s_axis_data_ready, 1'b0);
            check("t4_stall_valid", m_data_valid, 1'b1);
            check("t4_stall_data", m_data_data, make_data(32'h300, 16));
            check("t4_stall_last", m_data_last, 1'b0);
        end
        check("t4_words_stalled", words_in - w0, 16);
        @(posedge user_clk); #1;
        m_data_ready = 1'b1;
        for (int i = 16; i < 32; i++) send_word(32'h300 + 32'(i), 4'hF, i == 31);
        expect_beat("t4a", make_data(32'h300, 16), KEEP_ALL, 1'b0);
        expect_beat("t4b", make_data(32'h310, 16), KEEP_ALL, 1'b1);
        expect_cmd("t4", 64'h1300, 32'd128);
        check("t4_words_total", words_in - w0, 32);
        @(posedge user_clk); #1;
        check("t4_err_sticky", err_length_mismatch, 1'b1);
        check("t4_beats", stat_beats_out, 32'd6);
        check("t4_bytes", stat_bytes_in, 32'd294);

        // Zero length, back-to-back commands
        send_cmd(64'h2000, 32'd0);
        send_cmd(64'h3000, 32'd0);
        repeat (3) @(posedge user_clk);
        #1;
        expect_cmd("t5a", 64'h2000, 32'd0);
        expect_cmd("t5b", 64'h3000, 32'd0);
        check("t5_no_beat", beat_q.size(), 0);
        check("t5_idle", s_axis_cmd_ready, 1'b1);
        check("t5_no_data_ready", s_axis_data_ready, 1'b0);
        check("t5_beats", stat_beats_out, 32'd6);

        // Reset mid-transfer after 7 words
        send_cmd(64'h6000, 32'd64);
        for (int i = 0; i < 7; i++) send_word(32'h600 + 32'(i), 4'hF, 1'b0);
        s_axis_data_valid = 1'b1;
        s_axis_data_data  = 32'h607;
        check("t6_pre_ready", s_axis_data_ready, 1'b1);
        user_aresetn = 1'b0;
        #1;
        check("t6_rst_data_ready", s_axis_data_ready, 1'b0);
        check("t6_rst_data_valid", m_data_valid, 1'b0);
        check("t6_rst_cmd_valid", m_cmd_valid, 1'b0);
        check("t6_rst_cmd_ready", s_axis_cmd_ready, 1'b1);
        check("t6_rst_err", err_length_mismatch, 1'b0);
        check("t6_rst_stats", {stat_beats_out, stat_bytes_in}, 64'd0);
        s_axis_data_valid = 1'b0;
        beat_q.delete();
        cmd_q.delete();
        @(posedge user_clk); #1;
        user_aresetn = 1'b1;
        @(posedge user_clk); #1;
        send_cmd(64'h7000, 32'd8);
        send_word(32'h700, 4'hF, 1'b0);
        send_word(32'h701, 4'hF, 1'b1);
        expect_beat("t6", make_data(32'h700, 2), 64'hFF, 1'b1);
        expect_cmd("t6", 64'h7000, 32'd8);
        @(posedge user_clk); #1;
        check("t6_err", err_length_mismatch, 1'b0);
        check("t6_beats", stat_beats_out, 32'd1);
        check("t6_bytes", stat_bytes_in, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
